dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Memory-side responder for the core data-memory interface (Mem_Ctrl/DAddress/Ddout in, Ddin/acq out).
//  Serialises DRAM accesses from NCORES cores onto one single-port synchronous DRAM (1-cycle read latency).
//  Grants are round-robin. acq pulses once per completed transaction. Sits between the cores and DRAM in the multi-core top level.
// PARAMETERS
//  NCORES  2  number of requesting cores (>=1)
//  AW      8  data address width
//  DW      8  data width
// PORTS
//  CLK          in   1          system clock (clkdiv output); all logic on rising edge
//  rst          in   1          synchronous, active-high reset
//  Mem_Ctrl_bus in   4*NCORES   core i Mem_Ctrl at [4i+3:4i]; bit0=read req, bit1=write req, bits3:2 ignored
//  DAddress_bus in   AW*NCORES  core i data address at [AW*i+AW-1:AW*i]
//  Ddout_bus    in   DW*NCORES  core i write data
//  Ddin_bus     out  DW*NCORES  core i read-data register
//  acq          out  NCORES     acq[i]=1 for one cycle: core i transaction complete, Ddin valid (reads)
//  mem_address  out  AW         DRAM address
//  mem_data     out  DW         DRAM write data
//  mem_wren     out  1          DRAM write enable
//  mem_q        in   DW         DRAM read data, valid the cycle after address is sampled
//  busy         out  1          1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, acq=0, mem_wren=0, mem_address=0, mem_data=0, all Ddin regs=0, busy=0,
//   rr_last=NCORES-1 (core 0 has first priority). Reset mid-transaction aborts it; no acq pulse, no write.
//  req[i] = Mem_Ctrl[4i+1] | Mem_Ctrl[4i]; op is write if bit1=1 (write wins when both set).
//  FSM: IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE.
//   IDLE: if any req, pick first requesting i scanning rr_last+1, +2, ... (mod NCORES); latch g=i,
//    addr, wdata, op from core g at this edge; -> ACCESS. No req: stay, outputs idle.
//   ACCESS: mem_address=latched addr, mem_data=latched wdata, mem_wren=1 iff op=write. -> CAPTURE.
//   CAPTURE: mem_wren=0. If op=read, Ddin[g] <= mem_q at end of cycle. -> ACK.
//   ACK: acq[g]=1 (only bit set), rr_last <= g. -> IDLE.
//  Latency: request sampled at edge k in IDLE -> acq high during cycle k+3; max throughput 1 transaction/4 cycles.
//  Core contract: holds Mem_Ctrl/DAddress/Ddout until acq seen, then may change or drop them.
//   Request inputs are sampled only in IDLE; changes during ACCESS..ACK are ignored; a dropped request
//   still completes and acq still pulses.
//  A request still asserted in the IDLE cycle after its own ACK is a NEW transaction (core must deassert on acq).
//  Ddin[i] changes only on a read by core i; holds value otherwise (including across other cores' traffic).
//  mem_wren is high for exactly one cycle per write; never high outside ACCESS.
//  Addresses/data pass through unmodified; no width conversion; address wrap is DRAM's concern.
//  Outside ACCESS mem_address/mem_data hold their last values (no glitching to 0).
// TESTING
//  1 Write: core0 Mem_Ctrl=4'b0010, DAddress=8'h10, Ddout=8'hA5 -> mem_wren=1 one cycle with addr 10/data A5, acq[0] 3 cycles after sample.
//  2 Read: DRAM model holds A5 at 8'h10; core1 Mem_Ctrl=4'b0001 addr 10 -> acq[1] pulse, Ddin[1]=A5 in that cycle, Ddin[0] unchanged.
//  3 Contention: both cores request continuously from reset -> grants 0,1,0,1...; each acq one cycle, 4-cycle spacing.
//  4 Mem_Ctrl=4'b0011 addr 20 data 5C -> treated as write; Ddin unchanged; next read of 20 returns 5C.
//  5 Reset asserted in ACCESS of a write -> next cycle IDLE, mem_wren=0, acq=0, DRAM contents at addr unchanged.
//  6 Core0 drops request during CAPTURE -> acq[0] still pulses once; no second transaction starts.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Serialises data-memory accesses from NCORES cores onto one single-port
//   synchronous DRAM (read data appears the cycle after the address is
//   sampled). Grants rotate round-robin; each transaction walks
//   IDLE -> ACCESS -> CAPTURE -> ACK and pulses acq[g] once in ACK.
//
// Ports
//   CLK           system clock, rising edge
//   rst           synchronous active-high reset
//   Mem_Ctrl_bus  per-core control nibble (bit0 read req, bit1 write req)
//   DAddress_bus  per-core data address
//   Ddout_bus     per-core write data
//   Ddin_bus      per-core read-data registers
//   acq           per-core one-cycle completion pulse
//   mem_address   DRAM address
//   mem_data      DRAM write data
//   mem_wren      DRAM write enable
//   mem_q         DRAM read data
//   busy          high whenever a transaction is in flight
module dram_arbiter #(
  parameter int NCORES = 2,
  parameter int AW     = 8,
  parameter int DW     = 8
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [4*NCORES-1:0]  Mem_Ctrl_bus,
  input  logic [AW*NCORES-1:0] DAddress_bus,
  input  logic [DW*NCORES-1:0] Ddout_bus,
  output logic [DW*NCORES-1:0] Ddin_bus,
  output logic [NCORES-1:0]    acq,
  output logic [AW-1:0]        mem_address,
  output logic [DW-1:0]        mem_data,
  output logic                 mem_wren,
  input  logic [DW-1:0]        mem_q,
  output logic                 busy
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     grant_reg;
  logic [IW-1:0]     rr_last_reg;
  logic              op_write_reg;
  logic [AW-1:0]     addr_reg;
  logic [DW-1:0]     wdata_reg;
  logic [DW-1:0]     ddin_reg [NCORES];

  logic [NCORES-1:0] req;
  logic [NCORES-1:0] core_wr;
  logic [AW-1:0]     core_addr  [NCORES];
  logic [DW-1:0]     core_wdata [NCORES];

  logic              any_req;
  logic [IW-1:0]     pick;

  // Unpack the flat per-core buses.
  generate
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
      assign req[gi]        = Mem_Ctrl_bus[4*gi+1] | Mem_Ctrl_bus[4*gi];
      assign core_wr[gi]    = Mem_Ctrl_bus[4*gi+1];
      assign core_addr[gi]  = DAddress_bus[AW*gi +: AW];
      assign core_wdata[gi] = Ddout_bus[DW*gi +: DW];
      assign Ddin_bus[DW*gi +: DW] = ddin_reg[gi];
    end
  endgenerate

  // Round-robin pick: scan rr_last+1, rr_last+2, ... modulo NCORES.
  // The loop runs from the farthest offset down so the nearest requester
  // is the last (winning) assignment.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    any_req = 1'b0;
    pick    = '0;
    sum     = '0;
    idx     = '0;
    for (int off = NCORES; off >= 1; off--) begin
      sum = {1'b0, rr_last_reg} + (IW+1)'(off);
      if (sum >= (IW+1)'(NCORES)) sum = sum - (IW+1)'(NCORES);
      idx = sum[IW-1:0];
      if (req[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = CAPTURE;
      CAPTURE: state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. The DRAM bus mirrors the latched request, so it holds its
  // last value outside ACCESS. Write enable and acq are masked by rst so
  // a reset landing mid-transaction neither writes the DRAM nor acks.
  always_comb begin
    acq = '0;
    if (state_reg == ACK && !rst) acq[grant_reg] = 1'b1;
  end

  assign mem_wren    = (state_reg == ACCESS) && op_write_reg && !rst;
  assign mem_address = addr_reg;
  assign mem_data    = wdata_reg;
  assign busy        = (state_reg != IDLE);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_last_reg  <= IW'(NCORES-1);
      op_write_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      for (int i = 0; i < NCORES; i++) ddin_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any_req) begin
        grant_reg    <= pick;
        addr_reg     <= core_addr[pick];
        wdata_reg    <= core_wdata[pick];
        op_write_reg <= core_wr[pick];
      end
      // mem_q is valid during CAPTURE for the address driven in ACCESS.
      if (state_reg == CAPTURE && !op_write_reg) ddin_reg[grant_reg] <= mem_q;
      if (state_reg == ACK) rr_last_reg <= grant_reg;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed testbench for dram_arbiter (NCORES=2, AW=8, DW=8) with a
// behavioural single-port synchronous DRAM (1-cycle read latency).
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_ctrl;
  logic [15:0] daddr;
  logic [15:0] ddout;
  logic [15:0] ddin;
  logic [1:0]  acq;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q = 8'h00;
  logic        busy;

  logic [7:0]  dram [256] = '{default: 8'h00};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.NCORES(2), .AW(8), .DW(8)) dut (
    .CLK         (clk),
    .rst         (rst),
    .Mem_Ctrl_bus(mem_ctrl),
    .DAddress_bus(daddr),
    .Ddout_bus   (ddout),
    .Ddin_bus    (ddin),
    .acq         (acq),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .busy        (busy)
  );

  always @(posedge clk) begin
    if (mem_wren) dram[mem_address] <= mem_data;
    mem_q <= dram[mem_address];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ctrl = 8'h00; daddr = 16'h0; ddout = 16'h0;
    step(); step();
    n_cmp++; if ({busy, acq, mem_wren} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_ctl: busy/acq/wren=%b expected 0000", {busy, acq, mem_wren}); end
    n_cmp++; if ({mem_address, mem_data, ddin} !== 32'h0) begin n_bad++;
      $display("FAIL reset_data: addr/data/ddin=%h expected 00000000", {mem_address, mem_data, ddin}); end
    rst = 1'b0;
    // Bits 3:2 alone are not a request.
    mem_ctrl = 8'hCC;
    step(); step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL ignored_bits: busy=%b expected 0", busy); end
    mem_ctrl = 8'h00;
    $display("reset: done");
  endtask

  task automatic test_write();
    mem_ctrl = 8'h02; daddr = 16'h0010; ddout = 16'h00A5;
    step();  // sampled in IDLE -> ACCESS
    n_cmp++; if ({mem_wren, mem_address, mem_data, busy} !== {1'b1, 8'h10, 8'hA5, 1'b1}) begin n_bad++;
      $display("FAIL wr_access: wren=%b addr=%h data=%h busy=%b expected 1 10 A5 1", mem_wren, mem_address, mem_data, busy); end
    step();  // CAPTURE
    n_cmp++; if ({mem_wren, acq} !== 3'b000) begin n_bad++;
      $display("FAIL wr_capture: wren=%b acq=%b expected 0 00", mem_wren, acq); end
    step();  // ACK
    n_cmp++; if (acq !== 2'b01) begin n_bad++;
      $display("FAIL wr_acq: acq=%b expected 01", acq); end
    mem_ctrl = 8'h00;
    step();
    n_cmp++; if ({acq, busy, mem_address, mem_data} !== {3'b000, 8'h10, 8'hA5}) begin n_bad++;
      $display("FAIL wr_idle: acq=%b busy=%b addr=%h data=%h expected 00 0 10 A5", acq, busy, mem_address, mem_data); end
    n_cmp++; if (dram[8'h10] !== 8'hA5) begin n_bad++;
      $display("FAIL wr_dram: dram[10]=%h expected A5", dram[8'h10]); end
    $display("write: core0 addr 10 data A5");
  endtask

  task automatic test_read();
    mem_ctrl = 8'h10; daddr = 16'h1000; ddout = 16'h0;
    step(); step(); step();
    n_cmp++; if (acq !== 2'b10) begin n_bad++;
      $display("FAIL rd_acq: acq=%b expected 10", acq); end
    n_cmp++; if (ddin !== 16'hA500) begin n_bad++;
      $display("FAIL rd_ddin: ddin=%h expected A500", ddin); end
    mem_ctrl = 8'h00;
    step();
    $display("read: core1 addr 10 -> %h", ddin[15:8]);
  endtask

  task automatic test_both_bits();
    mem_ctrl = 8'h03; daddr = 16'h0020; ddout = 16'h005C;
    step();
    n_cmp++; if ({mem_wren, mem_address, mem_data} !== {1'b1, 8'h20, 8'h5C}) begin n_bad++;
      $display("FAIL both_access: wren=%b addr=%h data=%h expected 1 20 5C", mem_wren, mem_address, mem_data); end
    step(); step();
    n_cmp++; if ({acq, ddin} !== {2'b01, 16'hA500}) begin n_bad++;
      $display("FAIL both_ack: acq=%b ddin=%h expected 01 A500", acq, ddin); end
    mem_ctrl = 8'h00;
    step();
    // Read back address 20 on core 0.
    mem_ctrl = 8'h01; daddr = 16'h0020; ddout = 16'h0;
    step();
    n_cmp++; if (mem_wren !== 1'b0) begin n_bad++;
      $display("FAIL rb_wren: wren=%b expected 0", mem_wren); end
    step(); step();
    n_cmp++; if ({acq, ddin} !== {2'b01, 16'hA55C}) begin n_bad++;
      $display("FAIL rb_ddin: acq=%b ddin=%h expected 01 A55C", acq, ddin); end
    mem_ctrl = 8'h00;
    step();
    $display("both bits: core0 wrote 5C at 20, read back %h", ddin[7:0]);
  endtask

  task automatic test_drop();
    int pulses;
    mem_ctrl = 8'h01; daddr = 16'h0010; ddout = 16'h0;
    step(); step();      // now in CAPTURE
    mem_ctrl = 8'h00;    // core abandons the request
    step();
    n_cmp++; if ({acq, ddin[7:0]} !== {2'b01, 8'hA5}) begin n_bad++;
      $display("FAIL drop_ack: acq=%b ddin0=%h expected 01 A5", acq, ddin[7:0]); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (acq != 2'b00 || busy) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++;
      $display("FAIL drop_idle: active cycles=%0d expected 0", pulses); end
    $display("drop: single acq, arbiter idle afterwards");
  endtask

  task automatic test_reset_mid();
    mem_ctrl = 8'h20; daddr = 16'h3000; ddout = 16'h7700;
    step();              // ACCESS of a core1 write
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_wren !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_wren: wren=%b expected 0", mem_wren); end
    mem_ctrl = 8'h00;
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if ({busy, mem_wren, acq, ddin} !== 20'h0) begin n_bad++;
      $display("FAIL rstmid_state: busy=%b wren=%b acq=%b ddin=%h expected 0 0 00 0000", busy, mem_wren, acq, ddin); end
    n_cmp++; if (dram[8'h30] !== 8'h00) begin n_bad++;
      $display("FAIL rstmid_dram: dram[30]=%h expected 00", dram[8'h30]); end
    step();
    $display("reset mid-write: aborted");
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_acq;
    rst = 1'b1;
    mem_ctrl = 8'h11; daddr = 16'h2010; ddout = 16'h0;
    step(); step();
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      exp_acq = 2'b00;
      if (n % 4 == 3) exp_acq = (((n / 4) % 2) == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (acq !== exp_acq) begin n_bad++;
        $display("FAIL rr_cycle%0d: acq=%b expected %b", n, acq, exp_acq); end
      if (exp_acq != 2'b00) $display("rr: cycle %0d grant acq=%b", n, acq);
    end
    n_cmp++; if (ddin !== 16'h5CA5) begin n_bad++;
      $display("FAIL rr_ddin: ddin=%h expected 5CA5", ddin); end
    mem_ctrl = 8'h00;
    step(); step(); step(); step();
  endtask

  initial begin
    rst = 1'b1; mem_ctrl = 8'h00; daddr = 16'h0; ddout = 16'h0;
    test_reset();
    test_write();
    test_read();
    test_both_bits();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
